req_rr_arbiter: RTL and testbench

Sequential front end for the 8-to-3 encoder stage. Captures rising edges on eight asynchronous request lines and holds them as pending. Grants one pending channel at a time in round-robin order, presenting a one-hot grant plus a valid strobe. The encoder consumes the grant as its Y7..Y0 inputs and the valid as its enable, and returns an acknowledge when the code has been used.

---
 rtl/req_arb_pkg.sv | 35 +++
 rtl/req_edge_sync.sv | 41 ++++
 rtl/req_rr_arbiter.sv | 92 +++++++++
 tb/tb_req_rr_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/req_arb_pkg.sv
// Shared types and the round-robin pick function for req_rr_arbiter.
// Optional feature macro: REQ_ARB_SYNC_EN (used by req_edge_sync).
package req_arb_pkg;

    localparam int unsigned N_CH_DEF = 8;
    localparam int unsigned PTR_W    = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // Lowest pending index at or above ptr, wrapping; iterate downward so the
    // smallest offset from ptr is the last (winning) assignment.
    function automatic pick_t rr_pick(input logic [N_CH_DEF-1:0] pending,
                                      input logic [PTR_W-1:0]    ptr);
        pick_t            res;
        logic [PTR_W-1:0] k;
        res = '0;
        for (int i = N_CH_DEF - 1; i >= 0; i--) begin
            k = ptr + PTR_W'(i);
            if (pending[k]) begin
                res.found = 1'b1;
                res.idx   = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/req_edge_sync.sv
// Per-channel rising-edge detector, with a 2-flop synchronizer in front
// when REQ_ARB_SYNC_EN is defined.
module req_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    output logic o_edge
);

`ifdef REQ_ARB_SYNC_EN
    logic r_s1, r_s2, r_s3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_req;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_edge = r_s2 & ~r_s3;
`else
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_req;
        end
    end

    // req is already synchronous here, so the edge is taken straight off the pin.
    assign o_edge = i_req & ~r_prev;
`endif

endmodule

// File: rtl/req_rr_arbiter.sv
// Edge-capturing round-robin arbiter feeding the 8-to-3 encoder stage.
// Define REQ_ARB_SYNC_EN to add a 2-flop synchronizer on every req line.
module req_rr_arbiter
    import req_arb_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            ack,
    output logic [N_CH-1:0] grant,
    output logic            valid,
    output logic            drop
);

    logic [N_CH-1:0]  w_edge;
    logic [N_CH-1:0]  w_clr;
    pick_t            w_pick;

    logic [N_CH-1:0]  r_pending;
    logic [N_CH-1:0]  r_grant;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_sel;
    logic             r_valid;
    logic             r_drop;
    state_t           r_state;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        req_edge_sync u_edge (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_req  (req[i]),
            .o_edge (w_edge[i])
        );
    end

    assign w_pick = rr_pick(r_pending, r_ptr);
    assign w_clr  = (r_state == GRANT && ack) ? (N_CH'(1) << r_sel) : '0;

    // A new edge on the channel being acked re-arms it (set wins) and is not a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (|(w_edge & r_pending & ~w_clr)) begin
                r_drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick.found) begin
                        r_grant <= N_CH'(1) << w_pick.idx;
                        r_sel   <= w_pick.idx;
                        r_valid <= 1'b1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        r_grant <= '0;
                        r_valid <= 1'b0;
                        r_ptr   <= r_sel + PTR_W'(1);
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign valid = r_valid;
    assign drop  = r_drop;

endmodule

// File: tb/tb_req_rr_arbiter.sv
// Directed self-checking bench for req_rr_arbiter; latency follows REQ_ARB_SYNC_EN.
module tb_req_rr_arbiter;

`ifdef REQ_ARB_SYNC_EN
    localparam int EDGES = 4;
`else
    localparam int EDGES = 2;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic [7:0] grant;
    logic       valid;
    logic       drop;

    int n_checks;
    int n_fail;

    req_rr_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ack   (ack),
        .grant (grant),
        .valid (valid),
        .drop  (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 8'hFF; ack = 1'b0;
        tick; tick;
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL reset_grant: got %h want 00", grant); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", drop); end
        rst = 1'b0;
        repeat (EDGES - 1) tick;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_early: got valid %b want 0", valid); end
        tick;
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL reset_lat_valid: got %b want 1", valid); end
        n_checks++; if (grant !== 8'h01) begin n_fail++; $display("FAIL reset_lat_grant: got %h want 01", grant); end
        // reset while a grant is outstanding abandons everything
        rst = 1'b1; req = 8'h00;
        tick;
        n_checks++; if (valid !== 1'b0 || grant !== 8'h00) begin n_fail++; $display("FAIL midgrant_rst: got valid %b grant %h want 0 00", valid, grant); end
        n_checks++; if (dut.r_pending !== 8'h00) begin n_fail++; $display("FAIL midgrant_pend: got %h want 00", dut.r_pending); end
        tick;
        rst = 1'b0;
    endtask

    task automatic test_ack_idle;
        ack = 1'b1;
        tick; tick;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ack_idle_valid: got %b want 0", valid); end
        n_checks++; if (dut.r_ptr !== 3'd0) begin n_fail++; $display("FAIL ack_idle_ptr: got %0d want 0", dut.r_ptr); end
        ack = 1'b0;
    endtask

    task automatic test_single;
        req = 8'h20; ack = 1'b1;
        repeat (EDGES - 1) tick;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got valid %b want 0", valid); end
        tick;
        n_checks++; if (valid !== 1'b1 || grant !== 8'h20) begin n_fail++; $display("FAIL single_grant: got valid %b grant %h want 1 20", valid, grant); end
        tick;
        n_checks++; if (valid !== 1'b0 || grant !== 8'h00) begin n_fail++; $display("FAIL single_one_cycle: got valid %b grant %h want 0 00", valid, grant); end
        n_checks++; if (dut.r_ptr !== 3'd6) begin n_fail++; $display("FAIL single_ptr: got %0d want 6", dut.r_ptr); end
        n_checks++; if (dut.r_pending !== 8'h00) begin n_fail++; $display("FAIL single_pend: got %h want 00", dut.r_pending); end
        req = 8'h00; ack = 1'b0;
    endtask

    task automatic test_round_robin;
        req = 8'h84;
        repeat (EDGES) tick;
        n_checks++; if (valid !== 1'b1 || grant !== 8'h80) begin n_fail++; $display("FAIL rr_first: got valid %b grant %h want 1 80", valid, grant); end
        tick;
        n_checks++; if (grant !== 8'h80) begin n_fail++; $display("FAIL rr_first_hold: got %h want 80", grant); end
        ack = 1'b1;
        tick;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap: got valid %b want 0", valid); end
        n_checks++; if (dut.r_ptr !== 3'd0) begin n_fail++; $display("FAIL rr_ptr0: got %0d want 0", dut.r_ptr); end
        ack = 1'b0;
        tick;
        n_checks++; if (valid !== 1'b1 || grant !== 8'h04) begin n_fail++; $display("FAIL rr_second: got valid %b grant %h want 1 04", valid, grant); end
        tick;
        ack = 1'b1;
        tick;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rr_done: got valid %b want 0", valid); end
        n_checks++; if (dut.r_ptr !== 3'd3) begin n_fail++; $display("FAIL rr_ptr3: got %0d want 3", dut.r_ptr); end
        ack = 1'b0; req = 8'h00;
    endtask

    task automatic test_hold;
        req = 8'h08;
        repeat (EDGES) tick;
        n_checks++; if (valid !== 1'b1 || grant !== 8'h08) begin n_fail++; $display("FAIL hold_grant: got valid %b grant %h want 1 08", valid, grant); end
        for (int i = 0; i < 10; i++) begin
            if (i == 2) req = 8'h09;
            tick;
            n_checks++;
            if (valid !== 1'b1 || grant !== 8'h08) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got valid %b grant %h want 1 08", i, valid, grant);
            end
        end
        ack = 1'b1;
        tick;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got valid %b want 0", valid); end
        n_checks++; if (dut.r_ptr !== 3'd4) begin n_fail++; $display("FAIL hold_ptr: got %0d want 4", dut.r_ptr); end
        ack = 1'b0;
        tick;
        n_checks++; if (valid !== 1'b1 || grant !== 8'h01) begin n_fail++; $display("FAIL hold_next: got valid %b grant %h want 1 01", valid, grant); end
        ack = 1'b1;
        tick;
        ack = 1'b0; req = 8'h00;
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL hold_drop: got %b want 0", drop); end
    endtask

    task automatic test_merge_drop;
        req = 8'h02;
        repeat (EDGES) tick;
        n_checks++; if (grant !== 8'h02) begin n_fail++; $display("FAIL merge_blocker: got %h want 02", grant); end
        req = 8'h12; tick; req = 8'h02;
        repeat (4) tick;
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL merge_first: got drop %b want 0", drop); end
        req = 8'h12; tick; req = 8'h02;
        repeat (4) tick;
        n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL merge_drop: got drop %b want 1", drop); end
        n_checks++; if (dut.r_pending !== 8'h12) begin n_fail++; $display("FAIL merge_pend: got %h want 12", dut.r_pending); end
        ack = 1'b1; tick; ack = 1'b0;
        tick;
        n_checks++; if (valid !== 1'b1 || grant !== 8'h10) begin n_fail++; $display("FAIL merge_grant: got valid %b grant %h want 1 10", valid, grant); end
        ack = 1'b1; tick; ack = 1'b0;
        tick;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL merge_single: got valid %b want 0", valid); end
        n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL merge_sticky: got drop %b want 1", drop); end
        req = 8'h00; rst = 1'b1;
        tick; tick;
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL merge_rst_clear: got drop %b want 0", drop); end
        rst = 1'b0;
    endtask

    task automatic test_collide;
        req = 8'h08;
        repeat (EDGES) tick;
        n_checks++; if (valid !== 1'b1 || grant !== 8'h08) begin n_fail++; $display("FAIL coll_grant: got valid %b grant %h want 1 08", valid, grant); end
        req = 8'h00;
        repeat (EDGES) tick;
        req = 8'h08;
        repeat (EDGES - 2) tick;
        ack = 1'b1;
        tick;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL coll_ack: got valid %b want 0", valid); end
        n_checks++; if (dut.r_pending !== 8'h08) begin n_fail++; $display("FAIL coll_pend: got %h want 08", dut.r_pending); end
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL coll_drop: got %b want 0", drop); end
        ack = 1'b0;
        tick;
        n_checks++; if (valid !== 1'b1 || grant !== 8'h08) begin n_fail++; $display("FAIL coll_regrant: got valid %b grant %h want 1 08", valid, grant); end
        ack = 1'b1;
        tick;
        n_checks++; if (valid !== 1'b0 || dut.r_pending !== 8'h00) begin n_fail++; $display("FAIL coll_done: got valid %b pend %h want 0 00", valid, dut.r_pending); end
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL coll_drop_end: got %b want 0", drop); end
        ack = 1'b0; req = 8'h00;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; req = 8'h00; ack = 1'b0;
        test_reset;
        test_ack_idle;
        test_single;
        test_round_robin;
        test_hold;
        test_merge_drop;
        test_collide;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
